// File: rtl/tank_hit_manager.sv
// -----------------------------------------------------------------------------
// tank_hit_manager
//
// Player-side damage/score stage that sits directly upstream of an enemy
// instance. Once per frame it checks the enemy bullet against the player tank
// and produces the enemy's hit / tank_detroyed inputs. It also runs the
// lives / boom / respawn state machine and counts enemy kills from the
// enemy's enemy_detroyed level.
//
// Optional feature: define HIT_INVULN_EN to give the tank INVULN_FRAMES frames
// of hit immunity after every respawn.
//
// Ports:
//   clk_50MHz       in   1        system clock
//   reset           in   1        asynchronous, active-low
//   refresh_tick    in   1        1-cycle frame strobe
//   x_enemy_bullet  in   10       enemy bullet left x (bullet 4x4 px)
//   y_enemy_bullet  in   10       enemy bullet top y
//   x_tank          in   10       tank left x (tank 32x32 px)
//   y_tank          in   10       tank top y
//   enemy_detroyed  in   1        level: tank bullet overlaps enemy
//   hit             out  1        1-cycle pulse, enemy bullet struck the tank
//   tank_detroyed   out  1        high in BOOM and GAME_OVER
//   tank_respawn    out  1        1-cycle pulse, tank returns to start
//   lives           out  LIVES_W  remaining lives
//   score           out  SCORE_W  saturating kill count
//   game_over       out  1        high in GAME_OVER
// -----------------------------------------------------------------------------
module tank_hit_manager #(
  parameter int LIVES_INIT    = 3,
  parameter int BOOM_FRAMES   = 8,
  parameter int SCORE_W       = 10,
  parameter int INVULN_FRAMES = 60,
  parameter int LIVES_W       = $clog2(LIVES_INIT + 1)
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic               refresh_tick,
  input  logic [9:0]         x_enemy_bullet,
  input  logic [9:0]         y_enemy_bullet,
  input  logic [9:0]         x_tank,
  input  logic [9:0]         y_tank,
  input  logic               enemy_detroyed,
  output logic               hit,
  output logic               tank_detroyed,
  output logic               tank_respawn,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  // Counter sized so that BOOM_FRAMES == 1 still yields a non-zero width.
  localparam int BOOM_W = $clog2(BOOM_FRAMES + 1);
  localparam logic [BOOM_W-1:0] BOOM_LAST = BOOM_W'(BOOM_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_BOOM      = 2'd1,
    ST_RESPAWN   = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [BOOM_W-1:0]   boom_cnt_r, boom_cnt_nxt_s;
  logic [LIVES_W-1:0]  lives_r, lives_nxt_s;
  logic [SCORE_W-1:0]  score_r, score_nxt_s;
  logic                enemy_q_r;
  logic                hit_r, hit_nxt_s;
  logic                tank_detroyed_r, tank_detroyed_nxt_s;
  logic                tank_respawn_r, tank_respawn_nxt_s;
  logic                game_over_r, game_over_nxt_s;
  logic                take_hit_s;
  logic                kill_s;
  logic                overlap_s;
  logic                inv_active_s;
  logic [10:0]         xb_s, yb_s, xt_s, yt_s;

  // Widen to 11 bits so the +32 / +3 edges never wrap near the screen border.
  assign xb_s = {1'b0, x_enemy_bullet};
  assign yb_s = {1'b0, y_enemy_bullet};
  assign xt_s = {1'b0, x_tank};
  assign yt_s = {1'b0, y_tank};

  assign overlap_s = (xb_s < (xt_s + 11'd32)) && ((xb_s + 11'd3) >= xt_s) &&
                     (yb_s < (yt_s + 11'd32)) && ((yb_s + 11'd3) >= yt_s);

  // Rising edge of the enemy level: a held level counts as a single kill.
  assign kill_s = enemy_detroyed & ~enemy_q_r;

`ifdef HIT_INVULN_EN
  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  logic [INV_W-1:0] inv_cnt_r, inv_cnt_nxt_s;

  assign inv_active_s = (inv_cnt_r != '0);

  // Immunity counter: loaded on respawn, counts frames down while alive.
  always_comb begin
    inv_cnt_nxt_s = inv_cnt_r;
    if (state_r == ST_RESPAWN) begin
      inv_cnt_nxt_s = INV_W'(INVULN_FRAMES);
    end else if ((state_r == ST_ALIVE) && refresh_tick && inv_active_s) begin
      inv_cnt_nxt_s = inv_cnt_r - INV_W'(1);
    end else begin
      inv_cnt_nxt_s = inv_cnt_r;
    end
  end

  // Immunity counter register.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      inv_cnt_r <= '0;
    end else begin
      inv_cnt_r <= inv_cnt_nxt_s;
    end
  end
`else
  assign inv_active_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_r <= ST_ALIVE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the lives guard keeps ALIVE from ever underflowing.
  always_comb begin
    state_nxt_s = state_r;
    take_hit_s  = 1'b0;
    case (state_r)
      ST_ALIVE: begin
        if (refresh_tick && overlap_s && !inv_active_s && (lives_r != '0)) begin
          state_nxt_s = ST_BOOM;
          take_hit_s  = 1'b1;
        end else begin
          state_nxt_s = ST_ALIVE;
        end
      end
      ST_BOOM: begin
        if (refresh_tick && (boom_cnt_r == BOOM_LAST)) begin
          state_nxt_s = (lives_r == '0) ? ST_GAME_OVER : ST_RESPAWN;
        end else begin
          state_nxt_s = ST_BOOM;
        end
      end
      ST_RESPAWN:   state_nxt_s = ST_ALIVE;
      ST_GAME_OVER: state_nxt_s = ST_GAME_OVER;
      default:      state_nxt_s = ST_ALIVE;
    endcase
  end

  // Output/datapath logic: outputs are decoded from the next state so that
  // the registered copies line up with the state they describe.
  always_comb begin
    hit_nxt_s           = take_hit_s;
    tank_detroyed_nxt_s = (state_nxt_s == ST_BOOM) || (state_nxt_s == ST_GAME_OVER);
    tank_respawn_nxt_s  = (state_nxt_s == ST_RESPAWN);
    game_over_nxt_s     = (state_nxt_s == ST_GAME_OVER);

    if (take_hit_s) begin
      lives_nxt_s    = lives_r - LIVES_W'(1);
      boom_cnt_nxt_s = '0;
    end else if ((state_r == ST_BOOM) && refresh_tick) begin
      lives_nxt_s    = lives_r;
      boom_cnt_nxt_s = boom_cnt_r + BOOM_W'(1);
    end else begin
      lives_nxt_s    = lives_r;
      boom_cnt_nxt_s = boom_cnt_r;
    end

    if (kill_s && (state_r != ST_GAME_OVER) && (score_r != '1)) begin
      score_nxt_s = score_r + SCORE_W'(1);
    end else begin
      score_nxt_s = score_r;
    end
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      hit_r           <= 1'b0;
      tank_detroyed_r <= 1'b0;
      tank_respawn_r  <= 1'b0;
      game_over_r     <= 1'b0;
      lives_r         <= LIVES_W'(LIVES_INIT);
      score_r         <= '0;
      boom_cnt_r      <= '0;
      enemy_q_r       <= 1'b0;
    end else begin
      hit_r           <= hit_nxt_s;
      tank_detroyed_r <= tank_detroyed_nxt_s;
      tank_respawn_r  <= tank_respawn_nxt_s;
      game_over_r     <= game_over_nxt_s;
      lives_r         <= lives_nxt_s;
      score_r         <= score_nxt_s;
      boom_cnt_r      <= boom_cnt_nxt_s;
      enemy_q_r       <= enemy_detroyed;
    end
  end

  assign hit           = hit_r;
  assign tank_detroyed = tank_detroyed_r;
  assign tank_respawn  = tank_respawn_r;
  assign game_over     = game_over_r;
  assign lives         = lives_r;
  assign score         = score_r;

endmodule
